// File: rtl/avalon_st_arb_pkg.sv
// Shared types and sizing helpers for the Avalon-ST packet arbiter.
// The FSM state enum lives here so the top level and any future
// observers agree on the encoding.
package avalon_st_arb_pkg;

  // Arbitration FSM: IDLE picks a requester, XFER streams its packet.
  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_e;

  // Width of an Avalon-ST empty field for a given beat width.
  // A one-byte beat would need zero bits, so it is clamped to one.
  function automatic int emptyWidth(input int dataWidth);
    return (dataWidth / 8 > 1) ? $clog2(dataWidth / 8) : 1;
  endfunction

  // Width needed to index one of numPorts requesters.
  function automatic int portIdxWidth(input int numPorts);
    return (numPorts > 1) ? $clog2(numPorts) : 1;
  endfunction

endpackage

// File: rtl/avalon_st_pkt_arbiter_rr_arbiter.sv
// Combinational round-robin picker: returns the first asserted request
// at or after ptr_i, wrapping modulo NUM_PORTS.
module rr_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int IDX_WIDTH = 2
) (
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [IDX_WIDTH-1:0] ptr_i,
  output logic [IDX_WIDTH-1:0] gnt_idx_o,
  output logic                 gnt_valid_o
);

  logic [IDX_WIDTH:0] candIdx;

  // Walk the ports starting at ptr_i; ptr_i and the offset are both below
  // NUM_PORTS, so one conditional subtraction is enough to wrap.
  always_comb begin
    gnt_idx_o   = '0;
    gnt_valid_o = 1'b0;
    candIdx     = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      candIdx = {1'b0, ptr_i} + (IDX_WIDTH + 1)'(i);
      if (candIdx >= (IDX_WIDTH + 1)'(NUM_PORTS)) begin
        candIdx = candIdx - (IDX_WIDTH + 1)'(NUM_PORTS);
      end
      if (!gnt_valid_o && req_i[candIdx[IDX_WIDTH-1:0]]) begin
        gnt_valid_o = 1'b1;
        gnt_idx_o   = candIdx[IDX_WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/avalon_st_pkt_arbiter.sv
// Packet-granular round-robin arbiter merging NUM_PORTS Avalon-ST sources
// onto one sink through a single registered output stage. A grant is held
// from sop to eop so packets never interleave; the port that just finished
// drops to lowest priority.
// Optional feature macro: AVST_ARB_SOP_CHECK_EN -- when defined, only
// sop beats may win arbitration, stray non-sop beats seen while idle are
// drained and dropped, and the sticky sop_err output reports it.
module avalon_st_pkt_arbiter
  import avalon_st_arb_pkg::*;
#(
  parameter  int DATA_WIDTH  = 128,
  parameter  int NUM_PORTS   = 4,
  parameter  int EMPTY_WIDTH = emptyWidth(DATA_WIDTH),
  localparam int CH_WIDTH    = portIdxWidth(NUM_PORTS)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  in_data,
  input  logic [NUM_PORTS-1:0]                  in_valid,
  output logic [NUM_PORTS-1:0]                  in_ready,
  input  logic [NUM_PORTS-1:0][EMPTY_WIDTH-1:0] in_empty,
  input  logic [NUM_PORTS-1:0]                  in_sop,
  input  logic [NUM_PORTS-1:0]                  in_eop,
  output logic [DATA_WIDTH-1:0]                 out_data,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [EMPTY_WIDTH-1:0]                out_empty,
  output logic                                  out_sop,
  output logic                                  out_eop,
  output logic [CH_WIDTH-1:0]                   out_channel
`ifdef AVST_ARB_SOP_CHECK_EN
  ,
  output logic                                  sop_err
`endif
);

  arb_state_e           state_q;
  logic [CH_WIDTH-1:0]  ptr_q;
  logic [CH_WIDTH-1:0]  gnt_q;

  logic [DATA_WIDTH-1:0]  outData_q;
  logic                   outValid_q;
  logic [EMPTY_WIDTH-1:0] outEmpty_q;
  logic                   outSop_q;
  logic                   outEop_q;
  logic [CH_WIDTH-1:0]    outChannel_q;

  logic [NUM_PORTS-1:0] eligible;
  logic                 reqValid;
  logic [CH_WIDTH-1:0]  reqIdx;
  logic [CH_WIDTH-1:0]  nextPtr;
  logic                 outFree;
  logic                 accept;

`ifdef AVST_ARB_SOP_CHECK_EN
  logic [NUM_PORTS-1:0] dropMask;
  logic                 sopErr_q;

  // Only packet starts may compete; anything else seen while idle is junk
  // left over from a broken packet and gets flushed.
  always_comb begin
    eligible = in_valid & in_sop;
    dropMask = in_valid & ~in_sop;
  end
`else
  // Any valid source may compete; packet framing is trusted.
  always_comb begin
    eligible = in_valid;
  end
`endif

  rr_arbiter #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_WIDTH (CH_WIDTH)
  ) u_rr_arbiter (
    .req_i       (eligible),
    .ptr_i       (ptr_q),
    .gnt_idx_o   (reqIdx),
    .gnt_valid_o (reqValid)
  );

  // The output stage can take a beat when empty or when draining this cycle;
  // the port after the current grant becomes the new highest priority.
  always_comb begin
    outFree = !outValid_q || out_ready;
    accept  = (state_q == XFER) && in_valid[gnt_q] && outFree;
    nextPtr = (gnt_q == CH_WIDTH'(NUM_PORTS - 1)) ? '0 : gnt_q + CH_WIDTH'(1);
  end

  // Only the granted port sees ready while streaming; idle cycles accept
  // nothing except beats being flushed by the sop check.
  always_comb begin
    in_ready = '0;
    if (state_q == XFER) begin
      in_ready[gnt_q] = outFree;
    end
`ifdef AVST_ARB_SOP_CHECK_EN
    else begin
      in_ready = dropMask;
    end
`endif
  end

  // Arbitration FSM: latch the winner in IDLE, hold it until its eop beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (reqValid) begin
            gnt_q   <= reqIdx;
            state_q <= XFER;
          end
        end
        XFER: begin
          if (accept && in_eop[gnt_q]) begin
            state_q <= IDLE;
            ptr_q   <= nextPtr;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Single-entry output stage: load on accept, empty when drained with no
  // refill, otherwise hold every field steady under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outValid_q   <= 1'b0;
      outData_q    <= '0;
      outEmpty_q   <= '0;
      outSop_q     <= 1'b0;
      outEop_q     <= 1'b0;
      outChannel_q <= '0;
    end else if (accept) begin
      outValid_q   <= 1'b1;
      outData_q    <= in_data[gnt_q];
      outEmpty_q   <= in_empty[gnt_q];
      outSop_q     <= in_sop[gnt_q];
      outEop_q     <= in_eop[gnt_q];
      outChannel_q <= gnt_q;
    end else if (out_ready) begin
      outValid_q <= 1'b0;
    end
  end

`ifdef AVST_ARB_SOP_CHECK_EN
  // Sticky flag recording that at least one stray beat was thrown away.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sopErr_q <= 1'b0;
    end else if ((state_q == IDLE) && (|dropMask)) begin
      sopErr_q <= 1'b1;
    end
  end

  assign sop_err = sopErr_q;
`endif

  assign out_data    = outData_q;
  assign out_valid   = outValid_q;
  assign out_empty   = outEmpty_q;
  assign out_sop     = outSop_q;
  assign out_eop     = outEop_q;
  assign out_channel = outChannel_q;

endmodule

// File: tb/tb_avalon_st_pkt_arbiter.sv
// Scoreboard bench for avalon_st_pkt_arbiter. Per-port source queues feed
// the DUT; every beat expected downstream is queued in hand-derived order
// and a monitor pops and compares each beat the DUT hands over.
// Build with AVST_ARB_SOP_CHECK_EN defined to also exercise sop_err.
`timescale 1ns/1ps
module tb_avalon_st_pkt_arbiter;

  localparam int DW = 128;
  localparam int NP = 4;
  localparam int EW = 4;
  localparam int CW = 2;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [EW-1:0] empty;
    logic          sop;
    logic          eop;
    logic [CW-1:0] channel;
  } beat_t;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NP-1:0][DW-1:0]  in_data;
  logic [NP-1:0]          in_valid;
  logic [NP-1:0]          in_ready;
  logic [NP-1:0][EW-1:0]  in_empty;
  logic [NP-1:0]          in_sop;
  logic [NP-1:0]          in_eop;
  logic [DW-1:0]          out_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [EW-1:0]          out_empty;
  logic                   out_sop;
  logic                   out_eop;
  logic [CW-1:0]          out_channel;
`ifdef AVST_ARB_SOP_CHECK_EN
  logic                   sop_err;
`endif

  beat_t srcQ[NP][$];
  beat_t expQ[$];
  int    popCycLog[$];
  int    vectors = 0;
  int    miscompares = 0;
  int    cyc = 0;

  avalon_st_pkt_arbiter #(
    .DATA_WIDTH (DW),
    .NUM_PORTS  (NP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_empty    (in_empty),
    .in_sop      (in_sop),
    .in_eop      (in_eop),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_empty   (out_empty),
    .out_sop     (out_sop),
    .out_eop     (out_eop),
    .out_channel (out_channel)
`ifdef AVST_ARB_SOP_CHECK_EN
    ,
    .sop_err     (sop_err)
`endif
  );

  // Free-running 100 MHz clock and a cycle counter for latency checks.
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Unique, recognisable payload per port/beat/packet tag.
  function automatic logic [DW-1:0] mkData(input int port, input int beat, input int tag);
    return {32'hC0DE0000 + 32'(tag), 32'(port), 32'(beat), 32'hA5A5A5A5 ^ 32'(tag * 16 + port * 4 + beat)};
  endfunction

  // One comparison: bump the count, report and tally any difference.
  task automatic checkOutput(input string name, input logic [159:0] act, input logic [159:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Queue a packet on one source; the first expBeats beats are also expected
  // downstream, in the order this task is called.
  task automatic applyStimulus(input int port, input int nBeats, input int lastEmpty,
                               input int tag, input int expBeats, input bit withSop);
    beat_t bt;
    for (int b = 0; b < nBeats; b++) begin
      bt.data    = mkData(port, b, tag);
      bt.empty   = (b == nBeats - 1) ? EW'(lastEmpty) : '0;
      bt.sop     = withSop && (b == 0);
      bt.eop     = (b == nBeats - 1);
      bt.channel = CW'(port);
      srcQ[port].push_back(bt);
      if (b < expBeats) expQ.push_back(bt);
    end
  endtask

  // Bounded wait for the scoreboard to empty; a timeout counts as a failure.
  task automatic waitDrain(input string name, input int budget);
    int n = 0;
    while (expQ.size() > 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    vectors++;
    if (expQ.size() > 0) begin
      miscompares++;
      $display("[TB] FAIL %s_drain: %0d beats still outstanding, required 0", name, expQ.size());
      expQ.delete();
    end
  endtask

  // Source driver: retire a head beat the DUT took on the last edge, then
  // present the next head beat of each port just after the edge.
  initial begin : driver
    logic [NP-1:0] acc;
    beat_t h;
    in_valid = '0;
    in_data  = '0;
    in_empty = '0;
    in_sop   = '0;
    in_eop   = '0;
    forever begin
      @(negedge clk);
      acc = in_valid & in_ready;
      @(posedge clk);
      #1;
      for (int p = 0; p < NP; p++) begin
        if (acc[p] && srcQ[p].size() > 0) void'(srcQ[p].pop_front());
        if (srcQ[p].size() > 0) begin
          h           = srcQ[p][0];
          in_valid[p] = 1'b1;
          in_data[p]  = h.data;
          in_empty[p] = h.empty;
          in_sop[p]   = h.sop;
          in_eop[p]   = h.eop;
        end else begin
          in_valid[p] = 1'b0;
        end
      end
    end
  end

  // Monitor: every beat handed downstream must match the head of expQ.
  initial begin : monitor
    beat_t act;
    beat_t exp;
    forever begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        act.data    = out_data;
        act.empty   = out_empty;
        act.sop     = out_sop;
        act.eop     = out_eop;
        act.channel = out_channel;
        if (expQ.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL unexpected_beat: got ch %0d data %0h, required no beat", out_channel, out_data);
        end else begin
          exp = expQ.pop_front();
          checkOutput("beat_data", act.data, exp.data);
          checkOutput("beat_ctrl{empty,sop,eop,ch}", {act.empty, act.sop, act.eop, act.channel},
                      {exp.empty, exp.sop, exp.eop, exp.channel});
        end
        popCycLog.push_back(cyc);
      end
    end
  end

  // Safety net so a wedged DUT can never hang the run.
  initial begin : watchdog
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence.
  initial begin : main
    bit found;
    logic [4:0] validPattern;
    rst       = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state of every output.
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_out_fields", {out_data, out_empty, out_sop, out_eop, out_channel}, 0);
    checkOutput("reset_in_ready", in_ready, 0);
`ifdef AVST_ARB_SOP_CHECK_EN
    checkOutput("reset_sop_err", sop_err, 0);
`endif
    rst = 1'b0;
    @(negedge clk);

    // Single 3-beat packet on port 0: valid out in cycles 2..4.
    $display("[TB] single-port latency");
    applyStimulus(0, 3, 5, 1, 3, 1'b1);
    found = 0;
    for (int i = 0; i < 5 && !found; i++) begin
      @(negedge clk);
      if (in_valid[0]) found = 1;
    end
    checkOutput("t1_request_seen", found, 1);
    checkOutput("t1_c0_out_valid", out_valid, 0);
    checkOutput("t1_c0_in_ready", in_ready, 0);
    validPattern = 5'b01110;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) checkOutput("t1_c1_in_ready", in_ready, 4'b0001);
      checkOutput($sformatf("t1_c%0d_out_valid", c), out_valid, validPattern[5 - c]);
    end
    waitDrain("t1", 20);

    // Fresh reset, then all four ports request 2-beat packets together.
    $display("[TB] four simultaneous requesters");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    popCycLog.delete();
    for (int p = 0; p < NP; p++) applyStimulus(p, 2, p + 1, 2, 2, 1'b1);
    waitDrain("t2", 60);
    checkOutput("t2_beat_count", popCycLog.size(), 8);
    if (popCycLog.size() == 8) checkOutput("t2_span_cycles", popCycLog[7] - popCycLog[0], 10);

    // Backpressure mid-packet on port 0: output frozen, source stalled.
    $display("[TB] backpressure");
    applyStimulus(0, 4, 3, 3, 4, 1'b1);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (out_valid) found = 1;
    end
    checkOutput("t3_first_beat_seen", found, 1);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("t3_hold_valid", out_valid, 1);
      checkOutput("t3_hold_data", out_data, mkData(0, 1, 3));
      checkOutput("t3_hold_in_ready", in_ready, 0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    waitDrain("t3", 30);

    // Single-beat packets on ports 1 and 3 from ptr=1: 1,3,1,3 across wrap.
    $display("[TB] alternating single-beat packets");
    applyStimulus(1, 1, 7, 4, 1, 1'b1);
    applyStimulus(3, 1, 7, 4, 1, 1'b1);
    applyStimulus(1, 1, 6, 5, 1, 1'b1);
    applyStimulus(3, 1, 6, 5, 1, 1'b1);
    waitDrain("t4", 40);

    // Reset during the second beat of a 4-beat packet on port 2.
    $display("[TB] reset mid-packet");
    applyStimulus(1, 1, 2, 6, 1, 1'b1);
    applyStimulus(2, 4, 2, 6, 1, 1'b1);
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (out_valid && out_channel == 2'd2) found = 1;
    end
    checkOutput("t5_port2_started", found, 1);
    #1;
    rst = 1'b1;
    for (int p = 0; p < NP; p++) srcQ[p].delete();
    #1;
    checkOutput("t5_rst_out_valid", out_valid, 0);
    checkOutput("t5_rst_out_fields", {out_data, out_empty, out_sop, out_eop, out_channel}, 0);
    checkOutput("t5_rst_in_ready", in_ready, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    applyStimulus(1, 1, 1, 7, 1, 1'b1);
    applyStimulus(3, 1, 1, 7, 1, 1'b1);
    waitDrain("t5", 30);

`ifdef AVST_ARB_SOP_CHECK_EN
    // Stray non-sop beat on port 2 while idle is dropped and flagged.
    $display("[TB] sop check");
    applyStimulus(2, 1, 0, 8, 0, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("t6_sop_err_set", sop_err, 1);
    checkOutput("t6_stray_consumed", srcQ[2].size(), 0);
    applyStimulus(2, 2, 4, 9, 2, 1'b1);
    waitDrain("t6", 30);
    checkOutput("t6_sop_err_sticky", sop_err, 1);
`endif

    repeat (3) @(negedge clk);
    checkOutput("final_scoreboard_empty", expQ.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
